// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the hazard/pipeline-control unit.
// Holds the FSM state encoding, the forwarding select codes and a register compare helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-register taps into the hazard unit and the control outputs it returns.
// The master side is the datapath; the slave side is the hazard unit.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             id_halt;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic             mem_redirect;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;

    logic             pc_hold;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             halted;
    logic [CNT_W-1:0] cnt_cycle;
    logic [CNT_W-1:0] cnt_stall;
    logic [CNT_W-1:0] cnt_flush;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_halt,
               ex_rs1, ex_rs2, ex_rd, ex_memread,
               mem_rd, mem_regwrite, mem_redirect, wb_rd, wb_regwrite,
        input  pc_hold, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
               fwd_a, fwd_b, halted, cnt_cycle, cnt_stall, cnt_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_halt,
               ex_rs1, ex_rs2, ex_rd, ex_memread,
               mem_rd, mem_regwrite, mem_redirect, wb_rd, wb_regwrite,
        output pc_hold, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
               fwd_a, fwd_b, halted, cnt_cycle, cnt_stall, cnt_flush
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX operand; the younger EX/MEM result beats MEM/WB.
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_memRd,
    input  logic       i_memRegWrite,
    input  logic [4:0] i_wbRd,
    input  logic       i_wbRegWrite,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_memRegWrite && reg_match(i_memRd, i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_wbRegWrite && reg_match(i_wbRd, i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit: load-use stall, redirect flush, forwarding,
// ecall/ebreak halt drain and performance counters for the five-stage core.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [DCW-1:0]   r_drainCnt;
    logic [DCW-1:0]   w_nextDrainCnt;
    logic [CNT_W-1:0] r_cntCycle;
    logic [CNT_W-1:0] r_cntStall;
    logic [CNT_W-1:0] r_cntFlush;

    logic       w_loadUse;
    logic       w_luStall;
    logic       w_redirectFlush;
    logic       w_pcHold;
    logic       w_stallIfId;
    logic       w_stallIdEx;
    logic       w_flushIfId;
    logic       w_flushIdEx;
    logic [1:0] w_fwdA;
    logic [1:0] w_fwdB;

    assign w_loadUse = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                       ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                        (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

    assign w_luStall       = (r_state == ST_RUN) && w_loadUse && !bus.mem_redirect;
    assign w_redirectFlush = (r_state != ST_HALT) && bus.mem_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_drainCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_drainCnt <= w_nextDrainCnt;
        end
    end

    // The transition to HALT happens as the count steps off 1, so exactly
    // DRAIN_CYCLES drain cycles are spent before halted rises.
    always_comb begin
        w_nextState    = r_state;
        w_nextDrainCnt = r_drainCnt;
        case (r_state)
            ST_RUN: begin
                if (!bus.mem_redirect && !w_loadUse && bus.id_halt) begin
                    w_nextState    = ST_DRAIN;
                    w_nextDrainCnt = DCW'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (bus.mem_redirect) begin
                    w_nextState    = ST_RUN;
                    w_nextDrainCnt = '0;
                end else if (r_drainCnt <= DCW'(1)) begin
                    w_nextState    = ST_HALT;
                    w_nextDrainCnt = '0;
                end else begin
                    w_nextDrainCnt = r_drainCnt - 1'b1;
                end
            end
            ST_HALT: w_nextState = ST_HALT;
            default: begin
                w_nextState    = ST_RUN;
                w_nextDrainCnt = '0;
            end
        endcase
    end

    always_comb begin
        w_pcHold    = 1'b0;
        w_stallIfId = 1'b0;
        w_stallIdEx = 1'b0;
        w_flushIfId = 1'b0;
        w_flushIdEx = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.mem_redirect) begin
                        w_flushIfId = 1'b1;
                        w_flushIdEx = 1'b1;
                    end else if (w_loadUse) begin
                        w_pcHold    = 1'b1;
                        w_stallIfId = 1'b1;
                        w_stallIdEx = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    w_pcHold    = 1'b1;
                    w_flushIfId = 1'b1;
                    w_flushIdEx = bus.mem_redirect;
                end
                ST_HALT: begin
                    w_pcHold    = 1'b1;
                    w_flushIfId = 1'b1;
                    w_flushIdEx = 1'b1;
                end
                default: ;
            endcase
        end
    end

    fwd_sel u_fwdA (
        .i_rs          (bus.ex_rs1),
        .i_memRd       (bus.mem_rd),
        .i_memRegWrite (bus.mem_regwrite),
        .i_wbRd        (bus.wb_rd),
        .i_wbRegWrite  (bus.wb_regwrite),
        .o_sel         (w_fwdA)
    );

    fwd_sel u_fwdB (
        .i_rs          (bus.ex_rs2),
        .i_memRd       (bus.mem_rd),
        .i_memRegWrite (bus.mem_regwrite),
        .i_wbRd        (bus.wb_rd),
        .i_wbRegWrite  (bus.wb_regwrite),
        .o_sel         (w_fwdB)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntCycle <= '0;
            r_cntStall <= '0;
            r_cntFlush <= '0;
        end else begin
            if (r_state != ST_HALT) r_cntCycle <= r_cntCycle + 1'b1;
            if (w_luStall)          r_cntStall <= r_cntStall + 1'b1;
            if (w_redirectFlush)    r_cntFlush <= r_cntFlush + 1'b1;
        end
    end

    // Combinational controls are forced low during reset so nothing leaks out.
    assign bus.pc_hold     = w_pcHold;
    assign bus.stall_if_id = w_stallIfId;
    assign bus.stall_id_ex = w_stallIdEx;
    assign bus.flush_if_id = w_flushIfId;
    assign bus.flush_id_ex = w_flushIdEx;
    assign bus.fwd_a       = rst_n ? w_fwdA : FWD_RF;
    assign bus.fwd_b       = rst_n ? w_fwdB : FWD_RF;
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.cnt_cycle   = r_cntCycle;
    assign bus.cnt_stall   = r_cntStall;
    assign bus.cnt_flush   = r_cntFlush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   expCycle;
    bit   inHalt;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES (3),
        .CNT_W        (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic memread, input logic [4:0] exRd,
                                 input logic [4:0] rs1, input logic rs1Used,
                                 input logic [4:0] rs2, input logic rs2Used,
                                 input logic halt, input logic redirect);
        bus.ex_memread   = memread;
        bus.ex_rd        = exRd;
        bus.id_rs1       = rs1;
        bus.id_rs1_used  = rs1Used;
        bus.id_rs2       = rs2;
        bus.id_rs2_used  = rs2Used;
        bus.id_halt      = halt;
        bus.mem_redirect = redirect;
        #1;
    endtask

    task automatic clearInputs;
        bus.ex_rs1       = '0;
        bus.ex_rs2       = '0;
        bus.mem_rd       = '0;
        bus.mem_regwrite = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_regwrite  = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Edges taken in HALT do not advance the cycle counter.
    task automatic tick;
        if (!inHalt) expCycle++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expCycle = 0;
        inHalt   = 1'b0;
        rst_n    = 1'b0;
        clearInputs();

        // Hazard and forwarding conditions present while held in reset.
        bus.mem_regwrite = 1'b1;
        bus.mem_rd       = 5'd7;
        bus.ex_rs1       = 5'd7;
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_pc_hold", bus.pc_hold, 0);
        checkOutput("rst_stall_id_ex", bus.stall_id_ex, 0);
        checkOutput("rst_flush_if_id", bus.flush_if_id, 0);
        checkOutput("rst_fwd_a", bus.fwd_a, 0);
        checkOutput("rst_halted", bus.halted, 0);
        checkOutput("rst_cnt_cycle", bus.cnt_cycle, 0);

        repeat (2) @(posedge clk);
        #1;
        clearInputs();
        rst_n    = 1'b1;
        expCycle = 0;
        checkOutput("post_rst_cnt_stall", bus.cnt_stall, 0);

        // Load-use on rs1.
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_pc_hold", bus.pc_hold, 1);
        checkOutput("lu_stall_if_id", bus.stall_if_id, 1);
        checkOutput("lu_stall_id_ex", bus.stall_id_ex, 1);
        checkOutput("lu_flush_if_id", bus.flush_if_id, 0);
        tick();
        bus.mem_rd       = 5'd5;
        bus.mem_regwrite = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_cleared_stall", bus.stall_id_ex, 0);
        checkOutput("lu_cnt_stall", bus.cnt_stall, 1);

        // Load-use boundaries: x0 destination and an unused rs2.
        clearInputs();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_x0_no_stall", bus.stall_if_id, 0);
        applyStimulus(1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rs2_unused", bus.pc_hold, 0);
        applyStimulus(1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_rs2_used", bus.pc_hold, 1);

        // Redirect wins over load-use.
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("redir_flush_if_id", bus.flush_if_id, 1);
        checkOutput("redir_flush_id_ex", bus.flush_id_ex, 1);
        checkOutput("redir_stall_if_id", bus.stall_if_id, 0);
        checkOutput("redir_pc_hold", bus.pc_hold, 0);
        tick();
        clearInputs();
        checkOutput("redir_cnt_flush", bus.cnt_flush, 1);
        checkOutput("redir_cnt_stall", bus.cnt_stall, 1);

        // Forwarding priority and x0 handling.
        bus.mem_regwrite = 1'b1;
        bus.mem_rd       = 5'd7;
        bus.wb_regwrite  = 1'b1;
        bus.wb_rd        = 5'd7;
        bus.ex_rs1       = 5'd7;
        bus.ex_rs2       = 5'd0;
        #1;
        checkOutput("fwd_a_mem", bus.fwd_a, 1);
        checkOutput("fwd_b_x0", bus.fwd_b, 0);
        bus.mem_rd = 5'd0;
        #1;
        checkOutput("fwd_a_wb", bus.fwd_a, 2);
        bus.mem_rd       = 5'd7;
        bus.mem_regwrite = 1'b0;
        bus.ex_rs2       = 5'd7;
        #1;
        checkOutput("fwd_b_wb", bus.fwd_b, 2);
        bus.wb_regwrite = 1'b0;
        #1;
        checkOutput("fwd_b_rf", bus.fwd_b, 0);
        clearInputs();
        checkOutput("cnt_cycle_run", bus.cnt_cycle, expCycle);

        // Halt drain: three DRAIN cycles, then HALT.
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("halt_req_pc_hold", bus.pc_hold, 0);
        tick();
        clearInputs();
        checkOutput("drain1_pc_hold", bus.pc_hold, 1);
        checkOutput("drain1_flush_if_id", bus.flush_if_id, 1);
        checkOutput("drain1_flush_id_ex", bus.flush_id_ex, 0);
        tick();
        checkOutput("drain2_pc_hold", bus.pc_hold, 1);
        tick();
        checkOutput("drain3_pc_hold", bus.pc_hold, 1);
        checkOutput("drain3_halted", bus.halted, 0);
        tick();
        inHalt = 1'b1;
        checkOutput("halt_halted", bus.halted, 1);
        checkOutput("halt_flush_id_ex", bus.flush_id_ex, 1);
        checkOutput("halt_cnt_cycle", bus.cnt_cycle, expCycle);
        repeat (4) tick();
        checkOutput("halt_cnt_frozen", bus.cnt_cycle, expCycle);

        // Asynchronous reset out of HALT.
        rst_n = 1'b0;
        #1;
        checkOutput("rst_halt_halted", bus.halted, 0);
        checkOutput("rst_halt_pc_hold", bus.pc_hold, 0);
        checkOutput("rst_halt_flush_id_ex", bus.flush_id_ex, 0);
        checkOutput("rst_halt_cnt_cycle", bus.cnt_cycle, 0);
        rst_n    = 1'b1;
        expCycle = 0;
        inHalt   = 1'b0;
        #1;
        checkOutput("rst2_cnt_flush", bus.cnt_flush, 0);
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_run_stall", bus.stall_if_id, 1);
        tick();
        clearInputs();
        checkOutput("rst2_cnt_cycle", bus.cnt_cycle, 1);
        checkOutput("rst2_cnt_stall", bus.cnt_stall, 1);

        // Redirect in the second DRAIN cycle squashes the halt.
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        clearInputs();
        checkOutput("sq_drain1_pc_hold", bus.pc_hold, 1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("sq_flush_id_ex", bus.flush_id_ex, 1);
        tick();
        clearInputs();
        checkOutput("sq_run_pc_hold", bus.pc_hold, 0);
        repeat (4) tick();
        checkOutput("sq_never_halted", bus.halted, 0);
        checkOutput("sq_cnt_flush", bus.cnt_flush, 1);
        checkOutput("sq_cnt_cycle", bus.cnt_cycle, expCycle);

        // Redirect together with id_halt: no drain.
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("rh_flush_id_ex", bus.flush_id_ex, 1);
        tick();
        clearInputs();
        checkOutput("rh_no_drain", bus.pc_hold, 0);
        checkOutput("rh_cnt_flush", bus.cnt_flush, 2);

        // Load-use together with id_halt: stall first, halt afterwards.
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("lh_stall_id_ex", bus.stall_id_ex, 1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("lh_released_pc_hold", bus.pc_hold, 0);
        tick();
        clearInputs();
        checkOutput("lh_drain_pc_hold", bus.pc_hold, 1);
        checkOutput("lh_drain_stall_id_ex", bus.stall_id_ex, 0);
        checkOutput("lh_cnt_stall", bus.cnt_stall, 2);
        tick();
        tick();
        checkOutput("lh_drain3_halted", bus.halted, 0);
        tick();
        inHalt = 1'b1;
        checkOutput("lh_halted", bus.halted, 1);
        checkOutput("lh_cnt_cycle", bus.cnt_cycle, expCycle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
